// File: rtl/tdc_pkg.sv
// ============================================================================
//  Module      : tdc_pkg
//  Description : Shared types and helpers for the TDC sequencer and tdc_top.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdc_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        GAP     = 3'd2,
        CAPTURE = 3'd3,
        WAIT    = 3'd4,
        DONE    = 3'd5
    } seq_state_t;

    // Hamming weight of an N-tap line ranges 0..N inclusive.
    function automatic int hw_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int TDC_N    = 64;
    localparam int TDC_HW_W = hw_width(TDC_N);

endpackage

`default_nettype wire

// File: rtl/tdc_seq_accum.sv
// ============================================================================
//  Module      : tdc_seq_accum
//  Description : Batch accumulator: sum / count / timeout count / min / max.
//                Min/max registers exist only when TDC_SEQ_MINMAX_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_seq_accum
    import tdc_pkg::*;
#(
    parameter int              HW_W     = TDC_HW_W,
    parameter int              SAMP_W   = 8,
    parameter logic [HW_W-1:0] MIN_INIT = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clr,
    input  logic                     i_upd,
    input  logic [HW_W-1:0]          i_hw,
    input  logic                     i_tmo_inc,
    output logic [HW_W+SAMP_W-1:0]   o_sum,
    output logic [SAMP_W-1:0]        o_cnt,
    output logic [SAMP_W-1:0]        o_tmo,
    output logic [HW_W-1:0]          o_min,
    output logic [HW_W-1:0]          o_max
);

    localparam int c_SUM_W = HW_W + SAMP_W;

    logic [c_SUM_W-1:0] r_sum;
    logic [SAMP_W-1:0]  r_cnt;
    logic [SAMP_W-1:0]  r_tmo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_tmo <= '0;
        end else if (i_clr) begin
            r_sum <= '0;
            r_cnt <= '0;
            r_tmo <= '0;
        end else begin
            if (i_upd) begin
                r_sum <= r_sum + c_SUM_W'(i_hw);
                r_cnt <= r_cnt + SAMP_W'(1);
            end
            if (i_tmo_inc) begin
                r_tmo <= r_tmo + SAMP_W'(1);
            end
        end
    end

    assign o_sum = r_sum;
    assign o_cnt = r_cnt;
    assign o_tmo = r_tmo;

`ifdef TDC_SEQ_MINMAX_EN
    logic [HW_W-1:0] r_min;
    logic [HW_W-1:0] r_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= MIN_INIT;
            r_max <= '0;
        end else if (i_clr) begin
            r_min <= MIN_INIT;
            r_max <= '0;
        end else if (i_upd) begin
            if (i_hw < r_min) r_min <= i_hw;
            if (i_hw > r_max) r_max <= i_hw;
        end
    end

    assign o_min = r_min;
    assign o_max = r_max;
`else
    // MIN_INIT is zero in builds without min/max tracking.
    assign o_min = MIN_INIT;
    assign o_max = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/tdc_sample_sequencer.sv
// ============================================================================
//  Module      : tdc_sample_sequencer
//  Description : Drives TDC launch/capture/pulse-gen strobes, collects hamming
//                weights and returns batch statistics over valid/ready.
//                Optional min/max tracking: define TDC_SEQ_MINMAX_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_sample_sequencer
    import tdc_pkg::*;
#(
    parameter int N       = TDC_N,
    parameter int SAMP_W  = 8,
    parameter int GAP_W   = 4,
    parameter int TIMEOUT = 15,
    parameter int HW_W    = hw_width(N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [SAMP_W-1:0]      cfg_samples,
    input  logic [GAP_W-1:0]       cfg_gap,
    output logic                   launch_o,
    output logic                   capture_o,
    output logic                   pg_tog_o,
    output logic                   val_in_o,
    input  logic [HW_W-1:0]        tdc_hw_i,
    input  logic                   tdc_val_i,
    output logic                   busy_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [HW_W+SAMP_W-1:0] res_sum_o,
    output logic [SAMP_W-1:0]      res_cnt_o,
    output logic [SAMP_W-1:0]      res_tmo_o,
    output logic [HW_W-1:0]        res_min_o,
    output logic [HW_W-1:0]        res_max_o
);

    localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef TDC_SEQ_MINMAX_EN
    localparam logic [HW_W-1:0] c_MIN_RST = HW_W'(N);
`else
    localparam logic [HW_W-1:0] c_MIN_RST = '0;
`endif

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [SAMP_W-1:0]  r_samples;
    logic [GAP_W-1:0]   r_gap;
    logic [SAMP_W-1:0]  r_attempt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic [c_TMO_W-1:0] r_wait_cnt;
    logic               r_pg_tog;

    logic [GAP_W-1:0]   w_gap_eff;
    logic               w_tmo_expire;
    logic               w_sample_done;
    logic               w_last_attempt;
    logic               w_clr;
    logic               w_upd;
    logic               w_tmo_inc;

    assign w_gap_eff      = (r_gap == '0) ? GAP_W'(1) : r_gap;
    assign w_tmo_expire   = (r_wait_cnt == c_TMO_W'(TIMEOUT - 1));
    assign w_sample_done  = (r_state == WAIT) && (tdc_val_i || w_tmo_expire);
    assign w_last_attempt = (r_attempt == r_samples - SAMP_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = (cfg_samples == '0) ? DONE : LAUNCH;
            // A one-cycle gap has no GAP dwell: capture follows launch directly.
            LAUNCH:  w_next = (w_gap_eff == GAP_W'(1)) ? CAPTURE : GAP;
            GAP:     if (r_gap_cnt == w_gap_eff - GAP_W'(1)) w_next = CAPTURE;
            CAPTURE: w_next = WAIT;
            WAIT:    if (w_sample_done) w_next = w_last_attempt ? DONE : LAUNCH;
            DONE:    if (res_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        launch_o    = (r_state == LAUNCH);
        capture_o   = (r_state == CAPTURE);
        val_in_o    = (r_state == CAPTURE);
        busy_o      = (r_state != IDLE);
        res_valid_o = (r_state == DONE);
        w_clr       = ((r_state == IDLE) && start_i) || ((r_state == DONE) && res_ready_i);
        w_upd       = (r_state == WAIT) && tdc_val_i;
        w_tmo_inc   = (r_state == WAIT) && !tdc_val_i && w_tmo_expire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samples  <= '0;
            r_gap      <= '0;
            r_attempt  <= '0;
            r_gap_cnt  <= '0;
            r_wait_cnt <= '0;
            r_pg_tog   <= 1'b0;
        end else begin
            if ((r_state == IDLE) && start_i) begin
                r_samples <= cfg_samples;
                r_gap     <= cfg_gap;
                r_attempt <= '0;
            end
            if (r_state == LAUNCH) begin
                r_pg_tog  <= ~r_pg_tog;
                r_gap_cnt <= GAP_W'(1);
            end
            if (r_state == GAP) begin
                r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
            if (r_state == CAPTURE) begin
                r_wait_cnt <= '0;
            end
            if (r_state == WAIT) begin
                r_wait_cnt <= r_wait_cnt + c_TMO_W'(1);
            end
            if (w_sample_done) begin
                r_attempt <= r_attempt + SAMP_W'(1);
            end
        end
    end

    assign pg_tog_o = r_pg_tog;

    tdc_seq_accum #(
        .HW_W     (HW_W),
        .SAMP_W   (SAMP_W),
        .MIN_INIT (c_MIN_RST)
    ) u_accum (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_clr),
        .i_upd     (w_upd),
        .i_hw      (tdc_hw_i),
        .i_tmo_inc (w_tmo_inc),
        .o_sum     (res_sum_o),
        .o_cnt     (res_cnt_o),
        .o_tmo     (res_tmo_o),
        .o_min     (res_min_o),
        .o_max     (res_max_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_tdc_sample_sequencer.sv
// ============================================================================
//  Module      : tb_tdc_sample_sequencer
//  Description : Self-checking bench for tdc_sample_sequencer with a
//                timeline/statistics reference model and random stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tdc_sample_sequencer;

    localparam int N       = 64;
    localparam int SAMP_W  = 8;
    localparam int GAP_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int HW_W    = 7;
`ifdef TDC_SEQ_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif
    localparam int MIN_RST = MM ? N : 0;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start_i = 1'b0;
    logic [SAMP_W-1:0]      cfg_samples = '0;
    logic [GAP_W-1:0]       cfg_gap = '0;
    logic                   launch_o, capture_o, pg_tog_o, val_in_o;
    logic [HW_W-1:0]        tdc_hw_i = '0;
    logic                   tdc_val_i = 1'b0;
    logic                   busy_o, res_valid_o;
    logic                   res_ready_i = 1'b0;
    logic [HW_W+SAMP_W-1:0] res_sum_o;
    logic [SAMP_W-1:0]      res_cnt_o, res_tmo_o;
    logic [HW_W-1:0]        res_min_o, res_max_o;

    always #5 clk = ~clk;

    tdc_sample_sequencer #(
        .N(N), .SAMP_W(SAMP_W), .GAP_W(GAP_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .cfg_samples(cfg_samples), .cfg_gap(cfg_gap),
        .launch_o(launch_o), .capture_o(capture_o), .pg_tog_o(pg_tog_o),
        .val_in_o(val_in_o), .tdc_hw_i(tdc_hw_i), .tdc_val_i(tdc_val_i),
        .busy_o(busy_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_sum_o(res_sum_o), .res_cnt_o(res_cnt_o), .res_tmo_o(res_tmo_o),
        .res_min_o(res_min_o), .res_max_o(res_max_o)
    );

    int errors = 0;
    int checks = 0;
    int dly [256];   // response delay in cycles after capture; 0 = never
    int hwv [256];
    int launch_t [256];
    int cap_t [256];
    bit exp_pg = 1'b0;

    // Runs one batch against a timeline predicted from the sample rules.
    task automatic run_batch(input string name, input int ns, input int gap, input int hold);
        int ge, t_next, done_t, w, nl;
        int e_sum, e_cnt, e_tmo, e_min, e_max;
        bit pg0;
        logic [4:0] want, got;
        ge = (gap == 0) ? 1 : gap;
        e_sum = 0; e_cnt = 0; e_tmo = 0; e_min = N; e_max = 0;
        t_next = 1;
        for (int i = 0; i < ns; i++) begin
            launch_t[i] = t_next;
            cap_t[i]    = t_next + ge;
            if (dly[i] >= 1 && dly[i] <= TIMEOUT) begin
                e_sum += hwv[i];
                e_cnt++;
                if (hwv[i] < e_min) e_min = hwv[i];
                if (hwv[i] > e_max) e_max = hwv[i];
                w = dly[i];
            end else begin
                e_tmo++;
                w = TIMEOUT;
            end
            t_next = cap_t[i] + w + 1;
        end
        done_t = t_next;
        if (!MM) begin
            e_min = 0;
            e_max = 0;
        end
        pg0 = exp_pg;

        start_i = 1'b1;
        cfg_samples = SAMP_W'(ns);
        cfg_gap = GAP_W'(gap);
        for (int t = 1; t <= done_t; t++) begin
            @(negedge clk);
            want = 5'b0;
            nl = 0;
            for (int i = 0; i < ns; i++) begin
                if (launch_t[i] == t) want[4] = 1'b1;
                if (cap_t[i] == t) want[3:2] = 2'b11;
                if (launch_t[i] < t) nl++;
            end
            want[1] = 1'b1;
            want[0] = (t == done_t);
            got = {launch_o, capture_o, val_in_o, busy_o, res_valid_o};
            checks++;
            if (got !== want || pg_tog_o !== (pg0 ^ nl[0])) begin
                errors++;
                $display("FAIL %s_ctl_t%0d: got l/c/v/b/r=%b pg=%b, want %b pg=%b",
                         name, t, got, pg_tog_o, want, pg0 ^ nl[0]);
            end
            start_i = (t >= 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            cfg_samples = SAMP_W'($urandom);
            cfg_gap = GAP_W'($urandom);
            tdc_val_i = 1'b0;
            tdc_hw_i = HW_W'($urandom);
            for (int i = 0; i < ns; i++) begin
                if (dly[i] >= 1 && t == cap_t[i] + dly[i]) begin
                    tdc_val_i = 1'b1;
                    tdc_hw_i = HW_W'(hwv[i]);
                end else if (t >= launch_t[i] && t <= cap_t[i] && $urandom_range(0, 3) == 0) begin
                    tdc_val_i = 1'b1;
                end
            end
        end

        checks++;
        if (res_sum_o !== (HW_W+SAMP_W)'(e_sum)) begin
            errors++; $display("FAIL %s_sum: got %0d want %0d", name, res_sum_o, e_sum);
        end
        checks++;
        if (res_cnt_o !== SAMP_W'(e_cnt)) begin
            errors++; $display("FAIL %s_cnt: got %0d want %0d", name, res_cnt_o, e_cnt);
        end
        checks++;
        if (res_tmo_o !== SAMP_W'(e_tmo)) begin
            errors++; $display("FAIL %s_tmo: got %0d want %0d", name, res_tmo_o, e_tmo);
        end
        checks++;
        if (res_min_o !== HW_W'(e_min) || res_max_o !== HW_W'(e_max)) begin
            errors++;
            $display("FAIL %s_minmax: got %0d/%0d want %0d/%0d", name, res_min_o, res_max_o, e_min, e_max);
        end
        exp_pg = pg0 ^ ns[0];

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (res_valid_o !== 1'b1 || busy_o !== 1'b1 || launch_o !== 1'b0 ||
                res_sum_o !== (HW_W+SAMP_W)'(e_sum) || res_cnt_o !== SAMP_W'(e_cnt) ||
                res_tmo_o !== SAMP_W'(e_tmo)) begin
                errors++;
                $display("FAIL %s_hold%0d: got valid=%b busy=%b sum=%0d cnt=%0d tmo=%0d want 1 1 %0d %0d %0d",
                         name, h, res_valid_o, busy_o, res_sum_o, res_cnt_o, res_tmo_o, e_sum, e_cnt, e_tmo);
            end
            start_i = 1'($urandom_range(0, 1));
            tdc_val_i = 1'($urandom_range(0, 1));
        end

        res_ready_i = 1'b1;
        start_i = 1'b0;
        tdc_val_i = 1'b0;
        @(negedge clk);
        res_ready_i = 1'b0;
        checks++;
        if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_release: got valid=%b busy=%b want 0 0", name, res_valid_o, busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({launch_o, capture_o, val_in_o, pg_tog_o, busy_o, res_valid_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000000",
                     {launch_o, capture_o, val_in_o, pg_tog_o, busy_o, res_valid_o});
        end
        checks++;
        if (res_sum_o !== '0 || res_cnt_o !== '0 || res_tmo_o !== '0) begin
            errors++;
            $display("FAIL reset_res: got sum=%0d cnt=%0d tmo=%0d want 0", res_sum_o, res_cnt_o, res_tmo_o);
        end
        checks++;
        if (res_min_o !== HW_W'(MIN_RST) || res_max_o !== '0) begin
            errors++;
            $display("FAIL reset_minmax: got %0d/%0d want %0d/0", res_min_o, res_max_o, MIN_RST);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            dly[i] = 1;
            hwv[i] = 10 * (i + 1);
        end
        run_batch("basic", 3, 2, 0);
    endtask

    task automatic test_timeout();
        dly[0] = 0; dly[1] = 0;
        hwv[0] = 5; hwv[1] = 6;
        run_batch("timeout", 2, int'($urandom_range(1, 3)), 0);
    endtask

    task automatic test_zero_samples();
        run_batch("zero", 0, 5, 0);
    endtask

    task automatic test_hold();
        dly[0] = TIMEOUT; hwv[0] = 64;
        dly[1] = 3;       hwv[1] = 0;
        run_batch("hold", 2, 0, 10);
    endtask

    task automatic test_random();
        int ns, r;
        for (int b = 0; b < 8; b++) begin
            ns = int'($urandom_range(1, 6));
            for (int i = 0; i < ns; i++) begin
                r = int'($urandom_range(0, 20));
                dly[i] = (r > 16) ? 0 : ((r == 0) ? 1 : r);
                hwv[i] = int'($urandom_range(0, N));
            end
            run_batch($sformatf("rand%0d", b), ns, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid();
        start_i = 1'b1;
        cfg_samples = SAMP_W'(3);
        cfg_gap = GAP_W'(4);
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            start_i = 1'b0;
            tdc_val_i = (t == 6);
            tdc_hw_i = HW_W'(33);
        end
        checks++;
        if (busy_o !== 1'b1 || launch_o !== 1'b0 || capture_o !== 1'b0 || res_cnt_o !== SAMP_W'(1)) begin
            errors++;
            $display("FAIL rstmid_pre: got busy=%b launch=%b capture=%b cnt=%0d want 1 0 0 1",
                     busy_o, launch_o, capture_o, res_cnt_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({launch_o, capture_o, val_in_o, pg_tog_o, busy_o, res_valid_o} !== 6'b0 ||
            res_sum_o !== '0 || res_cnt_o !== '0 || res_tmo_o !== '0 ||
            res_min_o !== HW_W'(MIN_RST) || res_max_o !== '0) begin
            errors++;
            $display("FAIL rstmid_clear: got ctl=%b sum=%0d cnt=%0d min=%0d max=%0d want 0 0 0 %0d 0",
                     {launch_o, capture_o, val_in_o, pg_tog_o, busy_o, res_valid_o},
                     res_sum_o, res_cnt_o, res_min_o, res_max_o, MIN_RST);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_pg = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tdc_val_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || launch_o !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_after%0d: got valid=%b busy=%b launch=%b want 0 0 0",
                         t, res_valid_o, busy_o, launch_o);
            end
        end
        tdc_val_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timeout();
        test_zero_samples();
        test_hold();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
